// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, state encoding, class and fault codes for the multicycle controller
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV = 3'b000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU_REG = 3'd0,
        CL_ALU_IMM = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_SYSTEM  = 3'd5,
        CL_ILLEGAL = 3'd6
    } class_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_SYSTEM  = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT = 2'b11;

endpackage

// File: rtl/instr_class_decoder.sv
// rtl/instr_class_decoder.sv - maps {opcode, funct3} to an instruction class and a legal flag
module instr_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [2:0] instr_class,
    output logic       legal
);

    // Pure lookup; SYSTEM is only legal as ECALL/EBREAK (funct3 = 000)
    always_comb begin
        instr_class = CL_ILLEGAL;
        legal       = 1'b1;
        case (opcode)
            OPC_OP:     instr_class = CL_ALU_REG;
            OPC_OP_IMM,
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL,
            OPC_JALR:   instr_class = CL_ALU_IMM;
            OPC_LOAD:   instr_class = CL_LOAD;
            OPC_STORE:  instr_class = CL_STORE;
            OPC_BRANCH: instr_class = CL_BRANCH;
            OPC_SYSTEM: begin
                if (funct3 == F3_PRIV) begin
                    instr_class = CL_SYSTEM;
                end else begin
                    legal = 1'b0;
                end
            end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV64 sequencer; CTRL_PERF_CNT_EN adds cycle_cnt/instret
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int WORDSIZE    = 64,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                dm_ready,
    output logic                finished,
    output logic                rf_write_en,
    output logic                dm_write_en,
    output logic                dm_req,
    output logic                mem_to_reg,
    output logic                alu_src_imm,
    output logic                halted,
    output logic [1:0]          fault_code
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [WORDSIZE-1:0] cycle_cnt,
    output logic [WORDSIZE-1:0] instret
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_d;
    logic [9:0] op_q;
    logic [7:0] wait_cnt;
    logic [1:0] fault_d;
    logic [2:0] cls_raw;
    class_t     cls;
    logic       legal;
    logic       is_imm;
    logic       mem_timeout;

    // Classification always works on the captured instruction, never the live opcode
    instr_class_decoder u_decoder (
        .opcode      (op_q[6:0]),
        .funct3      (op_q[9:7]),
        .instr_class (cls_raw),
        .legal       (legal)
    );

    assign cls         = class_t'(cls_raw);
    assign is_imm      = (cls != CL_ALU_REG) && (cls != CL_BRANCH);
    assign mem_timeout = (wait_cnt == WAIT_LAST) && !dm_ready;

    // State, captured instruction, MEM wait counter and sticky fault code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            op_q       <= '0;
            wait_cnt   <= '0;
            fault_code <= FLT_NONE;
        end else begin
            state      <= state_d;
            fault_code <= fault_d;
            // Captured on entry to DECODE so the decoder output is valid throughout DECODE
            if (state == ST_FETCH && run) begin
                op_q <= {funct3, opcode};
            end
            // Held at zero outside MEM, so every MEM visit starts counting from zero
            if (state == ST_MEM) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Next-state, fault capture and datapath strobes
    always_comb begin
        state_d     = state;
        fault_d     = fault_code;
        finished    = 1'b0;
        rf_write_en = 1'b0;
        dm_write_en = 1'b0;
        dm_req      = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_FETCH: begin
                if (run) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_d = ST_HALT;
                    fault_d = FLT_ILLEGAL;
                end else if (cls == CL_SYSTEM) begin
                    state_d = ST_HALT;
                    fault_d = FLT_SYSTEM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_imm = is_imm;
                if (cls == CL_LOAD || cls == CL_STORE) begin
                    state_d = ST_MEM;
                end else if (cls == CL_BRANCH) begin
                    state_d  = ST_FETCH;
                    finished = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                alu_src_imm = is_imm;
                dm_req      = 1'b1;
                dm_write_en = (cls == CL_STORE);
                // A ready on the last allowed cycle still wins over the timeout
                if (dm_ready) begin
                    if (cls == CL_STORE) begin
                        state_d  = ST_FETCH;
                        finished = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (mem_timeout) begin
                    state_d = ST_HALT;
                    fault_d = FLT_TIMEOUT;
                end
            end
            ST_WB: begin
                alu_src_imm = is_imm;
                finished    = 1'b1;
                rf_write_en = 1'b1;
                mem_to_reg  = (cls == CL_LOAD);
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    // Free-running performance counters, frozen once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (state != ST_HALT) cycle_cnt <= cycle_cnt + WORDSIZE'(1);
            if (finished)         instret   <= instret + WORDSIZE'(1);
        end
    end
`endif

endmodule
